// File: rtl/wb_stage_pkg.sv
// Shared types and widths for the writeback stage: MEM->WS bus layout,
// stage FSM states and exception code constants.
package wb_stage_pkg;

    localparam int WS_DATA_W  = 32;
    localparam int WS_RADDR_W = 5;
    localparam int WS_ECODE_W = 6;
    localparam int WS_PC_W    = 32;
    localparam int WS_WE_W    = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ws_state_t;

    typedef struct packed {
        logic [WS_PC_W-1:0]    pc;
        logic                  gr_we;
        logic [WS_RADDR_W-1:0] dest;
        logic [WS_DATA_W-1:0]  result;
        logic                  ex;
        logic [WS_ECODE_W-1:0] ecode;
    } ms_bus_t;

    localparam logic [WS_ECODE_W-1:0] ECODE_INT = 6'h00;
    localparam logic [WS_ECODE_W-1:0] ECODE_SYS = 6'h0B;
    localparam logic [WS_ECODE_W-1:0] ECODE_BRK = 6'h0C;
    localparam logic [WS_ECODE_W-1:0] ECODE_INE = 6'h0D;

endpackage

// File: rtl/wb_retire_counter.sv
// Free-running retired-instruction counter: increments when en is high,
// wraps at the top of its range, clears asynchronously on reset.
module wb_retire_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers one MEM result per cycle, drives the regfile
// write port and ID forwarding, and commits exceptions (one FLUSH bubble).
// Optional debug trace ports/print are enabled by defining WS_DEBUG_TRACE_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W  = WS_DATA_W,
    parameter int RADDR_W = WS_RADDR_W,
    parameter int ECODE_W = WS_ECODE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ms_to_ws_valid,
    output logic               ws_allowin,
    input  logic [31:0]        ms_pc,
    input  logic               ms_gr_we,
    input  logic [RADDR_W-1:0] ms_dest,
    input  logic [DATA_W-1:0]  ms_result,
    input  logic               ms_ex,
    input  logic [ECODE_W-1:0] ms_ecode,
    output logic [3:0]         rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               ws_fwd_valid,
    output logic [RADDR_W-1:0] ws_fwd_dest,
    output logic [DATA_W-1:0]  ws_fwd_data,
    output logic               ws_ex,
    output logic [ECODE_W-1:0] ws_ecode,
    output logic [31:0]        ws_epc,
    output logic [31:0]        retire_cnt
`ifdef WS_DEBUG_TRACE_EN
    ,
    output logic [31:0]        debug_wb_pc,
    output logic [3:0]         debug_wb_rf_we,
    output logic [4:0]         debug_wb_rf_wnum,
    output logic [31:0]        debug_wb_rf_wdata
`endif
);

    ws_state_t state_reg;
    logic      ws_valid_reg;
    ms_bus_t   ws_bus_reg;
    ms_bus_t   ms_bus;
    logic      commit;

    assign ms_bus = '{pc: ms_pc, gr_we: ms_gr_we, dest: ms_dest,
                      result: ms_result, ex: ms_ex, ecode: ms_ecode};

    assign ws_allowin = (state_reg == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= RUN;
            ws_valid_reg <= 1'b0;
            ws_bus_reg   <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    ws_valid_reg <= ms_to_ws_valid;
                    if (ms_to_ws_valid) begin
                        ws_bus_reg <= ms_bus;
                    end
                    if (ws_valid_reg && ws_bus_reg.ex) begin
                        state_reg <= FLUSH;
                    end
                end
                FLUSH: begin
                    // MEM holds its entry; WS drains for exactly one cycle.
                    ws_valid_reg <= 1'b0;
                    state_reg    <= RUN;
                end
                default: begin
                    ws_valid_reg <= 1'b0;
                    state_reg    <= RUN;
                end
            endcase
        end
    end

    assign commit = ws_valid_reg && !ws_bus_reg.ex;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rf_we
            assign rf_we[gi] = commit && ws_bus_reg.gr_we;
        end
    endgenerate

    assign rf_waddr = ws_bus_reg.dest;
    assign rf_wdata = ws_bus_reg.result;

    // r0 writes still reach the regfile but must never be forwarded.
    assign ws_fwd_valid = commit && ws_bus_reg.gr_we && (ws_bus_reg.dest != '0);
    assign ws_fwd_dest  = ws_bus_reg.dest;
    assign ws_fwd_data  = ws_bus_reg.result;

    assign ws_ex    = ws_valid_reg && ws_bus_reg.ex;
    assign ws_ecode = ws_bus_reg.ecode;
    assign ws_epc   = ws_bus_reg.pc;

    wb_retire_counter #(.WIDTH(32)) u_retire (
        .clk   (clk),
        .reset (reset),
        .en    (commit),
        .count (retire_cnt)
    );

`ifdef WS_DEBUG_TRACE_EN
    assign debug_wb_pc       = ws_bus_reg.pc;
    assign debug_wb_rf_we    = rf_we;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && commit) begin
            $display("wb trace: pc=%08h dest=%0d data=%08h",
                     ws_bus_reg.pc, ws_bus_reg.dest, ws_bus_reg.result);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: reset, writes, r0, back-to-back,
// exception/flush, asynchronous reset mid-operation and counter wrap.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic        ms_ex;
    logic [5:0]  ms_ecode;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ws_fwd_valid;
    logic [4:0]  ws_fwd_dest;
    logic [31:0] ws_fwd_data;
    logic        ws_ex;
    logic [5:0]  ws_ecode;
    logic [31:0] ws_epc;
    logic [31:0] retire_cnt;
`ifdef WS_DEBUG_TRACE_EN
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt;

    wb_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ws_allowin     (ws_allowin),
        .ms_pc          (ms_pc),
        .ms_gr_we       (ms_gr_we),
        .ms_dest        (ms_dest),
        .ms_result      (ms_result),
        .ms_ex          (ms_ex),
        .ms_ecode       (ms_ecode),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .ws_fwd_valid   (ws_fwd_valid),
        .ws_fwd_dest    (ws_fwd_dest),
        .ws_fwd_data    (ws_fwd_data),
        .ws_ex          (ws_ex),
        .ws_ecode       (ws_ecode),
        .ws_epc         (ws_epc),
        .retire_cnt     (retire_cnt)
`ifdef WS_DEBUG_TRACE_EN
        ,
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic present(input logic [31:0] pc, input logic we, input logic [4:0] d,
                           input logic [31:0] r, input logic e, input logic [5:0] ec);
        ms_to_ws_valid = 1'b1;
        ms_pc = pc; ms_gr_we = we; ms_dest = d; ms_result = r; ms_ex = e; ms_ecode = ec;
    endtask

    task automatic idle();
        ms_to_ws_valid = 1'b0;
        ms_pc = '0; ms_gr_we = 1'b0; ms_dest = '0; ms_result = '0; ms_ex = 1'b0; ms_ecode = '0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (rf_we !== 4'h0 || ws_fwd_valid !== 1'b0 || ws_ex !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rf_we=%h fwd_valid=%b ws_ex=%b, required 0/0/0", rf_we, ws_fwd_valid, ws_ex);
        end
        checks++;
        if (ws_ecode !== 6'h0 || ws_epc !== 32'h0 || retire_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: ecode=%h epc=%h retire=%h, required 0/0/0", ws_ecode, ws_epc, retire_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ws_allowin !== 1'b1) begin
            errors++;
            $display("FAIL reset_allowin: got %b, required 1", ws_allowin);
        end
        $display("reset: checked reset values, retire=%0d", retire_cnt);
    endtask

    task automatic test_basic_write();
        @(negedge clk);
        present(32'h1c00_0000, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 6'h0);
        @(posedge clk);
        @(negedge clk);
        idle();
        checks++;
        if (rf_we !== 4'hF || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL basic_write: we=%h waddr=%0d wdata=%h, required F/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if (ws_fwd_valid !== 1'b1 || ws_fwd_dest !== 5'd5 || ws_fwd_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL basic_fwd: valid=%b dest=%0d data=%h, required 1/5/deadbeef", ws_fwd_valid, ws_fwd_dest, ws_fwd_data);
        end
        @(posedge clk);
        @(negedge clk);
        exp_cnt = 32'd1;
        checks++;
        if (retire_cnt !== exp_cnt || rf_we !== 4'h0) begin
            errors++;
            $display("FAIL basic_retire: retire=%0d we=%h, required %0d/0", retire_cnt, rf_we, exp_cnt);
        end
        $display("basic_write: pc=1c000000 dest=5 data=deadbeef retire=%0d", retire_cnt);
    endtask

    task automatic test_r0_write();
        present(32'h1c00_0004, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 6'h0);
        @(posedge clk);
        @(negedge clk);
        idle();
        checks++;
        if (rf_we !== 4'hF || rf_waddr !== 5'd0 || rf_wdata !== 32'h1234 || ws_fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL r0_write: we=%h waddr=%0d wdata=%h fwd=%b, required F/0/1234/0", rf_we, rf_waddr, rf_wdata, ws_fwd_valid);
        end
        @(posedge clk);
        @(negedge clk);
        exp_cnt = exp_cnt + 32'd1;
        checks++;
        if (retire_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL r0_retire: retire=%0d, required %0d", retire_cnt, exp_cnt);
        end
        $display("r0_write: dest=0 data=1234 retire=%0d", retire_cnt);
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        exp_cnt = 32'd0;
        for (int i = 0; i < 8; i++) begin
            present(32'h1c00_0100 + 32'(i * 4), 1'b1, 5'(i + 1), 32'h0000_0100 + 32'(i), 1'b0, 6'h0);
            checks++;
            if (ws_allowin !== 1'b1) begin
                errors++;
                $display("FAIL b2b_allowin[%0d]: got %b, required 1", i, ws_allowin);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (rf_we !== 4'hF || rf_waddr !== 5'(i + 1) || rf_wdata !== 32'h0000_0100 + 32'(i)) begin
                errors++;
                $display("FAIL b2b_write[%0d]: we=%h waddr=%0d wdata=%h, required F/%0d/%h",
                         i, rf_we, rf_waddr, rf_wdata, i + 1, 32'h100 + 32'(i));
            end
            $display("back_to_back[%0d]: dest=%0d data=%h", i, rf_waddr, rf_wdata);
        end
        idle();
        @(posedge clk);
        @(negedge clk);
        exp_cnt = 32'd8;
        checks++;
        if (retire_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL b2b_retire: retire=%0d, required 8", retire_cnt);
        end
    endtask

    task automatic test_exception();
        present(32'h1c00_0040, 1'b1, 5'd7, 32'h0BAD_0BAD, 1'b1, ECODE_SYS);
        @(posedge clk);
        @(negedge clk);
        idle();
        checks++;
        if (ws_ex !== 1'b1 || ws_ecode !== 6'h0B || ws_epc !== 32'h1c00_0040) begin
            errors++;
            $display("FAIL ex_pulse: ex=%b ecode=%h epc=%h, required 1/0b/1c000040", ws_ex, ws_ecode, ws_epc);
        end
        checks++;
        if (rf_we !== 4'h0 || ws_fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL ex_nowrite: we=%h fwd=%b, required 0/0", rf_we, ws_fwd_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ws_ex !== 1'b0 || ws_allowin !== 1'b0) begin
            errors++;
            $display("FAIL ex_flush: ex=%b allowin=%b, required 0/0", ws_ex, ws_allowin);
        end
        present(32'h1c00_0044, 1'b1, 5'd9, 32'h0000_AA55, 1'b0, 6'h0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rf_we !== 4'h0 || ws_allowin !== 1'b1 || retire_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL ex_blocked: we=%h allowin=%b retire=%0d, required 0/1/%0d", rf_we, ws_allowin, retire_cnt, exp_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        idle();
        checks++;
        if (rf_we !== 4'hF || rf_waddr !== 5'd9 || rf_wdata !== 32'h0000_AA55) begin
            errors++;
            $display("FAIL ex_next_accept: we=%h waddr=%0d wdata=%h, required F/9/aa55", rf_we, rf_waddr, rf_wdata);
        end
        @(posedge clk);
        @(negedge clk);
        exp_cnt = exp_cnt + 32'd1;
        checks++;
        if (retire_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL ex_retire: retire=%0d, required %0d", retire_cnt, exp_cnt);
        end
        $display("exception: ecode=0b epc=1c000040 then dest=9 retire=%0d", retire_cnt);
    endtask

    task automatic test_reset_midop();
        present(32'h1c00_0080, 1'b1, 5'd3, 32'h3333_3333, 1'b0, 6'h0);
        @(posedge clk);
        @(negedge clk);
        idle();
        checks++;
        if (rf_we !== 4'hF) begin
            errors++;
            $display("FAIL midop_pre: we=%h, required F", rf_we);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rf_we !== 4'h0 || ws_fwd_valid !== 1'b0 || retire_cnt !== 32'h0) begin
            errors++;
            $display("FAIL midop_async: we=%h fwd=%b retire=%0d, required 0/0/0", rf_we, ws_fwd_valid, retire_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (rf_we !== 4'h0 || ws_ex !== 1'b0 || ws_allowin !== 1'b1) begin
            errors++;
            $display("FAIL midop_after: we=%h ex=%b allowin=%b, required 0/0/1", rf_we, ws_ex, ws_allowin);
        end
        @(negedge clk);
        checks++;
        if (retire_cnt !== 32'h0) begin
            errors++;
            $display("FAIL midop_cnt: retire=%0d, required 0", retire_cnt);
        end
        $display("reset_midop: entry dropped, retire=%0d", retire_cnt);
    endtask

    task automatic test_counter_wrap();
        force dut.u_retire.count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.u_retire.count_reg;
        present(32'h1c00_00c0, 1'b0, 5'd4, 32'h4444_4444, 1'b0, 6'h0);
        @(posedge clk);
        @(negedge clk);
        idle();
        checks++;
        if (retire_cnt !== 32'hFFFF_FFFF || rf_we !== 4'h0) begin
            errors++;
            $display("FAIL wrap_pre: retire=%h we=%h, required ffffffff/0", retire_cnt, rf_we);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (retire_cnt !== 32'h0) begin
            errors++;
            $display("FAIL wrap: retire=%h, required 0", retire_cnt);
        end
        $display("counter_wrap: retire=%h", retire_cnt);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        exp_cnt = 32'd0;
        test_reset();
        test_basic_write();
        test_r0_write();
        test_back_to_back();
        test_exception();
        test_reset_midop();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
